// File: rtl/arbiter_pkg.sv
// Shared types and priority-encode helpers for the 16-way bank arbiter.
package arbiter_pkg;
  localparam int NUM_REQ  = 16;
  localparam int IDX_W    = 4;
  localparam int REQ_SIZE = 32;

  typedef logic [REQ_SIZE-1:0] req_word_t;
  typedef logic [NUM_REQ-1:0]  req_vec_t;
  typedef logic [IDX_W-1:0]    req_idx_t;

  function automatic req_idx_t lowest_idx(input req_vec_t v);
    req_idx_t idx;
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (v[i]) idx = req_idx_t'(i);
    end
    return idx;
  endfunction

  // Two's-complement trick isolates the lowest set bit.
  function automatic req_vec_t lowest_onehot(input req_vec_t v);
    return v & (~v + req_vec_t'(1));
  endfunction
endpackage

// File: rtl/bank_arbiter_rr_picker.sv
// Combinational round-robin pick: search above last_grant first, then wrap.
module rr_picker
  import arbiter_pkg::*;
(
  input  req_vec_t req,
  input  req_idx_t last_grant,
  output req_vec_t grant,
  output req_idx_t grant_idx
);
  req_vec_t above_mask;
  req_vec_t masked;
  req_vec_t sel;

  always_comb begin
    // When last_grant is the top bank the shift overflows to zero and the mask empties.
    above_mask = ~((req_vec_t'(2) << last_grant) - req_vec_t'(1));
    masked     = req & above_mask;
    sel        = (|masked) ? masked : req;
    grant      = lowest_onehot(sel);
    grant_idx  = lowest_idx(sel);
  end
endmodule

// File: rtl/bank_arbiter.sv
// 16-way bank arbiter: registered one-hot Ack, then granted word forwarded a cycle later.
// Define ARB_FIXED_PRIORITY_EN for strict lowest-index-wins priority instead of round-robin.
module bank_arbiter #(
  parameter int REQ_SIZE = 32,
  parameter int NUM_REQ  = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                Req,
  input  logic [NUM_REQ-1:0]                Valid,
  input  logic [NUM_REQ-1:0][REQ_SIZE-1:0]  Data_in,
  output logic [REQ_SIZE-1:0]               Data_out,
  output logic [NUM_REQ-1:0]                Ack,
  output logic                              Wr_en
);
  import arbiter_pkg::*;

  req_vec_t pick_grant;
  req_idx_t pick_idx;
  req_idx_t gidx_p1;
  logic     vld_p1;

`ifdef ARB_FIXED_PRIORITY_EN
  always_comb begin
    pick_grant = lowest_onehot(Req);
    pick_idx   = lowest_idx(Req);
  end
`else
  req_idx_t last_grant;

  rr_picker u_picker (
    .req        (Req),
    .last_grant (last_grant),
    .grant      (pick_grant),
    .grant_idx  (pick_idx)
  );

  // Reset to the top bank so the first search starts at bank 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last_grant <= req_idx_t'(NUM_REQ - 1);
    else if (|Req) last_grant <= pick_idx;
  end
`endif

  // Stage 1: grant register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Ack     <= '0;
      gidx_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      Ack     <= pick_grant;
      gidx_p1 <= pick_idx;
      vld_p1  <= |Req;
    end
  end

  // Stage 2: forward the granted bank's word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Data_out <= '0;
      Wr_en    <= 1'b0;
    end else if (vld_p1) begin
      Data_out <= Data_in[gidx_p1];
      Wr_en    <= Valid[gidx_p1];
    end else begin
      Wr_en    <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bank_arbiter.sv
// Self-checking bench for bank_arbiter: directed scenarios plus randomized traffic vs. a reference model.
module tb_bank_arbiter;
  logic               clk;
  logic               rst_n;
  logic [15:0]        Req;
  logic [15:0]        Valid;
  logic [15:0][31:0]  data_in;
  logic [31:0]        Data_out;
  logic [15:0]        Ack;
  logic               Wr_en;

  int n_chk = 0;
  int n_err = 0;

  bank_arbiter #(.REQ_SIZE(32), .NUM_REQ(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Req      (Req),
    .Valid    (Valid),
    .Data_in  (data_in),
    .Data_out (Data_out),
    .Ack      (Ack),
    .Wr_en    (Wr_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: winner is the first requester at offset 1..16 from the last grant.
  function automatic int ref_pick(input logic [15:0] req, input int last);
    int w;
    w = -1;
`ifdef ARB_FIXED_PRIORITY_EN
    for (int k = 15; k >= 0; k--) if (req[k]) w = k;
    if (last < -1) w = -1;
`else
    for (int k = 16; k >= 1; k--) if (req[(last + k) % 16]) w = (last + k) % 16;
`endif
    return w;
  endfunction

  int          m_last;
  int          m_g;
  logic        m_gv;
  logic [15:0] m_ack;
  logic        m_wr;
  logic [31:0] m_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_last <= 15;
      m_g    <= 0;
      m_gv   <= 1'b0;
      m_ack  <= '0;
      m_wr   <= 1'b0;
      m_data <= '0;
    end else begin
      m_wr <= m_gv && Valid[m_g];
      if (m_gv) m_data <= data_in[m_g];
      if (ref_pick(Req, m_last) >= 0) begin
        m_g    <= ref_pick(Req, m_last);
        m_last <= ref_pick(Req, m_last);
        m_gv   <= 1'b1;
        m_ack  <= 16'(1) << ref_pick(Req, m_last);
      end else begin
        m_gv   <= 1'b0;
        m_ack  <= '0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cmp_model();
    chk("model_ack",  32'(Ack),   32'(m_ack));
    chk("model_wr",   32'(Wr_en), 32'(m_wr));
    chk("model_data", Data_out,   m_data);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cmp_model();
  endtask

  task automatic set_default_data();
    for (int i = 0; i < 16; i++) data_in[i] = 32'h1000_0000 + 32'(i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 1'b1;
    Req   = '0;
    Valid = '0;
    set_default_data();
    #2 rst_n = 1'b0;
    Req = 16'hFFFF;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ack",  32'(Ack),   32'h0);
      chk("rst_wr",   32'(Wr_en), 32'h0);
      chk("rst_data", Data_out,   32'h0);
    end

    // Full rotation with every bank requesting
    rst_n = 1'b1;
    Valid = 16'hFFFF;
    for (int n = 1; n <= 16; n++) begin
      step();
`ifndef ARB_FIXED_PRIORITY_EN
      chk("rot_ack", 32'(Ack), 32'(16'(1) << (n - 1)));
`else
      chk("fix_ack", 32'(Ack), 32'h0001);
`endif
      if (n >= 2) begin
        chk("rot_data", Data_out, 32'h1000_0000 + 32'(n - 2));
        chk("rot_wr",   32'(Wr_en), 32'h1);
      end
    end

    // Sparse wrap across the 15 -> 0 boundary
    Req = 16'h8001;
    for (int k = 0; k < 4; k++) begin
      step();
`ifndef ARB_FIXED_PRIORITY_EN
      chk("wrap_ack", 32'(Ack), (k % 2 == 0) ? 32'h0001 : 32'h8000);
`endif
    end

    // Empty grant: slot consumed, nothing written
    Req = 16'h0010; Valid = 16'h0000;
    step();
    chk("empty_ack", 32'(Ack), 32'h0010);
    Req = '0;
    step();
    chk("empty_wr",  32'(Wr_en), 32'h0);
    chk("empty_ack0", 32'(Ack), 32'h0);
    Valid = 16'hFFFF;

    // Single requester drops Req on Ack
    Req = 16'h0004;
    step();
    chk("single_ack", 32'(Ack), 32'h0004);
    Req = '0;
    step();
    chk("single_ack0", 32'(Ack),   32'h0);
    chk("single_wr",   32'(Wr_en), 32'h1);
    chk("single_data", Data_out,   32'h1000_0002);
    step();
    chk("single_wr0",  32'(Wr_en), 32'h0);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      case ($urandom_range(0, 3))
        0: Req = 16'($urandom);
        1: Req = 16'($urandom) & 16'($urandom) & 16'($urandom);
        2: Req = '0;
        default: Req = 16'(1) << $urandom_range(0, 15);
      endcase
      Valid = 16'($urandom);
      for (int i = 0; i < 16; i++) data_in[i] = $urandom;
      step();
    end

    // Mid-stream reset while bank 8 holds Ack
    set_default_data();
    Valid = 16'hFFFF;
    Req   = 16'hFFFF;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 9; n++) step();
`ifndef ARB_FIXED_PRIORITY_EN
    chk("mid_pre_ack", 32'(Ack), 32'h0100);
`endif
    rst_n = 1'b0;
    #1;
    chk("mid_ack",  32'(Ack),   32'h0);
    chk("mid_wr",   32'(Wr_en), 32'h0);
    chk("mid_data", Data_out,   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("mid_post_ack", 32'(Ack), 32'h0001);
    step();
    chk("mid_post_data", Data_out, 32'h1000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
    $finish;
  end
endmodule
